// File: rtl/path_delay_sequencer.sv
// Times rising/falling propagation through one delay chain over RUNS launch/relax runs,
// accumulating saturating sums, the worst rise count, a sticky timeout and a threshold alarm.
module path_delay_sequencer #(
  parameter int CW      = 16,
  parameter int RUNS    = 4,
  parameter int SETTLE  = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [CW+7:0] thresh_i,
  output logic          path_in_o,
  input  logic          path_out_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW+7:0] rise_sum_o,
  output logic [CW+7:0] fall_sum_o,
  output logic [CW-1:0] rise_max_o,
  output logic          timeout_o,
  output logic          alarm_o
);
  localparam int SW = CW + 8;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_RISE_WAIT, S_FALL_WAIT, S_NEXT, S_FINISH
  } state_t;

  function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a, input logic [CW-1:0] b);
    logic [SW:0] s;
    s = {1'b0, a} + {{(SW+1-CW){1'b0}}, b};
    return s[SW] ? {SW{1'b1}} : s[SW-1:0];
  endfunction

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic          path_in_q, path_in_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          timeout_q, timeout_d, alarm_q, alarm_d;
  logic [SW-1:0] rise_sum_q, rise_sum_d, fall_sum_q, fall_sum_d, thr_q, thr_d;
  logic [CW-1:0] rise_max_q, rise_max_d, cnt_q, cnt_d, tmr_q, tmr_d;
  logic [7:0]    idx_q, idx_d;

  logic [CW-1:0] meas, low_cnt, tmr_inc, rec;
  logic [7:0]    idx_inc;
  logic [SW:0]   total;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      path_in_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      alarm_q    <= 1'b0;
      rise_sum_q <= '0;
      fall_sum_q <= '0;
      thr_q      <= '0;
      rise_max_q <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= path_out_i;
      sync2_q    <= sync1_q;
      path_in_q  <= path_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      alarm_q    <= alarm_d;
      rise_sum_q <= rise_sum_d;
      fall_sum_q <= fall_sum_d;
      thr_q      <= thr_d;
      rise_max_q <= rise_max_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    path_in_d  = path_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    alarm_d    = alarm_q;
    rise_sum_d = rise_sum_q;
    fall_sum_d = fall_sum_q;
    thr_d      = thr_q;
    rise_max_d = rise_max_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    idx_d      = idx_q;
    // cnt is 1 on the launch cycle; subtracting 1 makes a zero-delay path read as the sync depth
    meas       = cnt_q - CW'(1);
    low_cnt    = sync2_q ? '0 : cnt_q + CW'(1);
    tmr_inc    = tmr_q + CW'(1);
    rec        = '0;
    idx_inc    = idx_q + 8'd1;
    total      = {1'b0, rise_sum_q} + {1'b0, fall_sum_q};

    case (state_q)
      S_IDLE: begin
        path_in_d = 1'b0;
        if (start_i) begin
          thr_d      = thresh_i;
          rise_sum_d = '0;
          fall_sum_d = '0;
          rise_max_d = '0;
          timeout_d  = 1'b0;
          alarm_d    = 1'b0;
          idx_d      = '0;
          cnt_d      = '0;
          tmr_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = low_cnt;
        tmr_d = tmr_inc;
        if (low_cnt == CW'(SETTLE)) begin
          path_in_d = 1'b1;
          cnt_d     = CW'(1);
          state_d   = S_RISE_WAIT;
        end else if (tmr_inc == CW'(TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = S_NEXT;
        end
      end
      S_RISE_WAIT: begin
        if (sync2_q || cnt_q == CW'(TIMEOUT)) begin
          rec        = sync2_q ? meas : CW'(TIMEOUT);
          timeout_d  = timeout_q | ~sync2_q;
          rise_sum_d = sat_add(rise_sum_q, rec);
          if (rec > rise_max_q) rise_max_d = rec;
          path_in_d  = 1'b0;
          cnt_d      = CW'(1);
          state_d    = S_FALL_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FALL_WAIT: begin
        if (!sync2_q || cnt_q == CW'(TIMEOUT)) begin
          rec        = !sync2_q ? meas : CW'(TIMEOUT);
          timeout_d  = timeout_q | sync2_q;
          fall_sum_d = sat_add(fall_sum_q, rec);
          state_d    = S_NEXT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_NEXT: begin
        idx_d = idx_inc;
        if (idx_inc == 8'(RUNS)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          alarm_d = total > {1'b0, thr_q};
          state_d = S_FINISH;
        end else begin
          cnt_d   = '0;
          tmr_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign path_in_o  = path_in_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rise_sum_o = rise_sum_q;
  assign fall_sum_o = fall_sum_q;
  assign rise_max_o = rise_max_q;
  assign timeout_o  = timeout_q;
  assign alarm_o    = alarm_q;
endmodule
